// File: rtl/score_pkg.sv
// Shared types and constants for the score display: converter states,
// BCD sizing, the 7-segment font and the digit-index encoding.
package score_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam int BCD_W     = 4;
    localparam int MAX_SCORE = 99;

    // Segment patterns, bit0=a .. bit6=g, active-high
    localparam logic [6:0] SEG_FONT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic DIG_ONES = 1'b0;
    localparam logic DIG_TENS = 1'b1;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: clamps the binary score to 99 and
// produces two BCD nibbles over BW shift cycles, with a valid pulse in DONE.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int BW = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BW-1:0]    value,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens,
    output logic             valid,
    output logic             busy
);
    localparam int SR_W = 2*BCD_W + BW;
    localparam int CW   = $clog2(BW+1);

    conv_state_t   state;
    logic [BW-1:0] last_q;
    logic [BW-1:0] clamped;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [CW-1:0] cnt;

    always_comb begin
        clamped = (value > BW'(MAX_SCORE)) ? BW'(MAX_SCORE) : value;
        sr_adj  = sr;
        if (sr[BW +: BCD_W] >= BCD_W'(5))
            sr_adj[BW +: BCD_W] = sr[BW +: BCD_W] + BCD_W'(3);
        if (sr[BW+BCD_W +: BCD_W] >= BCD_W'(5))
            sr_adj[BW+BCD_W +: BCD_W] = sr[BW+BCD_W +: BCD_W] + BCD_W'(3);
    end

    // busy stays up through the cycle after DONE so it brackets the latch edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_q <= '0;
            sr     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != last_q) begin
                        sr     <= {{(2*BCD_W){1'b0}}, clamped};
                        last_q <= value;
                        cnt    <= '0;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr   <= sr_adj << 1;
                    cnt  <= cnt + 1'b1;
                    busy <= 1'b1;
                    if (cnt == CW'(BW-1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ones  = sr[BW +: BCD_W];
    assign tens  = sr[BW+BCD_W +: BCD_W];
    assign valid = (state == DONE);
endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed 7-segment driver for the score counter.
// Optional leading-zero blanking of the tens digit: define SCORE_DISPLAY_LZB_EN.
module score_display
    import score_pkg::*;
#(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          busy_o
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0]    ref_q;
    logic             idx_q;
    logic [BCD_W-1:0] ones, tens;
    logic [BCD_W-1:0] ones_q, tens_q;
    logic [BCD_W-1:0] cur;
    logic             valid;
    logic [6:0]       seg_next;

    bin2bcd_seq #(.BW(BW)) u_conv (
        .clk   (clk_i),
        .rst_n (rst_i),
        .value (value_i),
        .ones  (ones),
        .tens  (tens),
        .valid (valid),
        .busy  (busy_o)
    );

    always_comb begin
        cur      = (idx_q == DIG_TENS) ? tens_q : ones_q;
        seg_next = (cur <= BCD_W'(9)) ? SEG_FONT[cur] : 7'h00;
`ifdef SCORE_DISPLAY_LZB_EN
        if (idx_q == DIG_TENS && tens_q == '0)
            seg_next = 7'h00;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ref_q     <= '0;
            idx_q     <= DIG_ONES;
            ones_q    <= '0;
            tens_q    <= '0;
            seg_o     <= 7'h00;
            dig_sel_o <= 2'b00;
        end else begin
            if (ref_q == RW'(REFRESH_DIV-1)) begin
                ref_q <= '0;
                idx_q <= ~idx_q;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            if (valid) begin
                ones_q <= ones;
                tens_q <= tens;
            end
            seg_o     <= seg_next;
            dig_sel_o <= (idx_q == DIG_TENS) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (BW=7, REFRESH_DIV=4).
module tb_score_display;
    localparam int BW  = 7;
    localparam int DIV = 4;

    localparam logic [6:0] FONT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
`ifdef SCORE_DISPLAY_LZB_EN
    localparam logic [6:0] T0 = 7'h00;
`else
    localparam logic [6:0] T0 = 7'h3F;
`endif

    typedef struct {
        logic [6:0] value;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
    } vec_t;

    typedef struct {
        int         v;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [BW-1:0] value_i;
    logic [6:0]    seg_o;
    logic [1:0]    dig_sel_o;
    logic          busy_o;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t sb[$];

    score_display #(.BW(BW), .REFRESH_DIV(DIV)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .value_i   (value_i),
        .seg_o     (seg_o),
        .dig_sel_o (dig_sel_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (FONT[i] == s) return i;
        return -1;
    endfunction

    function automatic int dec_tens(input logic [6:0] s);
`ifdef SCORE_DISPLAY_LZB_EN
        if (s == 7'h00) return 0;
`endif
        return dec(s);
    endfunction

    // counts the cycles busy is high, returning once it has risen and fallen
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (busy_o) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic get_frame(output logic [6:0] o, output logic [6:0] t, output bit ok);
        bit so, st;
        so = 1'b0; st = 1'b0; o = 'x; t = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (dig_sel_o == 2'b01) begin o = seg_o; so = 1'b1; end
            if (dig_sel_o == 2'b10) begin t = seg_o; st = 1'b1; end
            if (so && st) break;
        end
        ok = so && st;
    endtask

    task automatic measure_period(output int n);
        logic [1:0] prev;
        n = 0;
        prev = dig_sel_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (dig_sel_o != prev) break;
        end
        prev = dig_sel_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            n++;
            if (dig_sel_o != prev) break;
        end
    endtask

    task automatic frame_vs_sb(input string tag);
        logic [6:0] o, t;
        bit ok;
        exp_t e;
        get_frame(o, t, ok);
        check({tag, "_frame_seen"}, 32'(ok), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_ones_seg"}, 32'(o), 32'(e.ones_seg));
            check({tag, "_tens_seg"}, 32'(t), 32'(e.tens_seg));
        end
    endtask

    initial begin
        vec_t tbl[10];
        int n, m;
        bit ok;
        logic [6:0] o, t;
        exp_t e;

        tbl[0] = '{7'd42,  7'h5B, 7'h66};
        tbl[1] = '{7'd115, 7'h6F, 7'h6F};
        tbl[2] = '{7'd99,  7'h6F, 7'h6F};
        tbl[3] = '{7'd100, 7'h6F, 7'h6F};
        tbl[4] = '{7'd7,   7'h07, T0};
        tbl[5] = '{7'd10,  7'h3F, 7'h06};
        tbl[6] = '{7'd0,   7'h3F, T0};
        tbl[7] = '{7'd127, 7'h6F, 7'h6F};
        tbl[8] = '{7'd58,  7'h7F, 7'h6D};
        tbl[9] = '{7'd5,   7'h6D, T0};

        // reset state
        rst_i = 1'b0;
        value_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_seg", 32'(seg_o), 32'h00);
        check("rst_dig_sel", 32'(dig_sel_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("first_dig_sel", 32'(dig_sel_o), 32'h1);
        check("first_seg", 32'(seg_o), 32'h3F);
        check("first_busy", 32'(busy_o), 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (dig_sel_o == 2'b10) begin ok = 1'b1; break; end
        end
        check("init_tens_seen", 32'(ok), 32'd1);
        check("init_tens_seg", 32'(seg_o), 32'(T0));
        check("init_busy_low", 32'(busy_o), 32'h0);
        measure_period(n);
        check("digit_period_a", 32'(n), 32'(DIV));
        measure_period(n);
        check("digit_period_b", 32'(n), 32'(DIV));

        // table-driven conversions
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            value_i = tbl[i].value;
            sb.push_back('{int'(tbl[i].value), tbl[i].ones_seg, tbl[i].tens_seg});
            count_busy(n);
            check("busy_len", 32'(n), 32'(BW+2));
            frame_vs_sb("tbl");
        end

        // 58 arrives while 37 is still shifting: both convert back to back
        @(negedge clk_i);
        value_i = 7'd37;
        m = 0;
        repeat (2) begin
            @(negedge clk_i);
            if (busy_o) m++;
        end
        value_i = 7'd58;
        sb.push_back('{58, 7'h7F, 7'h6D});
        count_busy(n);
        check("busy_len_back2back", 32'(n + m), 32'(2*(BW+2)));
        frame_vs_sb("late58");

        // full sweep with decoded digits
        for (int v = 0; v < 100; v++) begin
            @(negedge clk_i);
            value_i = BW'(v);
            sb.push_back('{v, FONT[v%10], FONT[v/10]});
            count_busy(n);
            check("sweep_busy_len", 32'(n), 32'(BW+2));
            get_frame(o, t, ok);
            check("sweep_frame_seen", 32'(ok), 32'd1);
            e = sb.pop_front();
            check("sweep_ones_digit", 32'(dec(o)), 32'(e.v % 10));
            check("sweep_tens_digit", 32'(dec_tens(t)), 32'(e.v / 10));
        end

        // reset during the third SHIFT cycle of 73
        @(negedge clk_i);
        value_i = 7'd73;
        repeat (3) @(negedge clk_i);
        check("pre_abort_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0;
        #1;
        check("abort_seg", 32'(seg_o), 32'h00);
        check("abort_dig_sel", 32'(dig_sel_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                check("rel_dig_sel", 32'(dig_sel_o), 32'h1);
                check("rel_seg", 32'(seg_o), 32'h3F);
            end
            if (dig_sel_o == 2'b01 && seg_o == 7'h4F) begin n = i; break; end
        end
        check("reconv73_latency_ok", 32'(n > 0 && n <= BW+3), 32'd1);
        wait_idle(ok);
        check("reconv73_idle", 32'(ok), 32'd1);
        sb.push_back('{73, 7'h4F, 7'h07});
        frame_vs_sb("reconv73");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
